// File: rtl/fmul_pkg.sv
// Shared definitions for the arbitrated 24-bit float multiplier: format widths,
// field positions and the result word that travels through the result FIFOs.
package fmul_pkg;

    localparam int FLOAT_W  = 24;
    localparam int EXP_W    = 7;
    localparam int MANT_W   = 16;

    localparam int SIGN_POS = FLOAT_W - 1;
    localparam int EXP_MSB  = SIGN_POS - 1;
    localparam int EXP_LSB  = MANT_W;
    localparam int MANT_MSB = MANT_W - 1;
    localparam int MANT_LSB = 0;

    typedef struct packed {
        logic [FLOAT_W-1:0] data;
        logic               ovf;
        logic               unf;
    } fmul_result_t;

    localparam int RESULT_W = $bits(fmul_result_t);

    function automatic logic sign_of(input logic [FLOAT_W-1:0] x);
        return x[SIGN_POS];
    endfunction

    function automatic logic [EXP_W-1:0] exp_of(input logic [FLOAT_W-1:0] x);
        return x[EXP_MSB:EXP_LSB];
    endfunction

    function automatic logic [MANT_W-1:0] mant_of(input logic [FLOAT_W-1:0] x);
        return x[MANT_MSB:MANT_LSB];
    endfunction

endpackage

// File: rtl/fmul_result_fifo.sv
// First-word-fall-through result FIFO with occupancy output; push and pop may
// coincide at any occupancy, including full.
module fmul_result_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 26,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign valid   = (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; entries are only visible once count says so.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fmul_arbiter.sv
// Round-robin front end sharing one non-stalling pipelined float multiplier
// between two requesters, with credit-protected per-requester result FIFOs.
module fmul_arbiter
    import fmul_pkg::*;
#(
    parameter int LATENCY    = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [FLOAT_W-1:0] req0_a,
    input  logic [FLOAT_W-1:0] req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [FLOAT_W-1:0] req1_a,
    input  logic [FLOAT_W-1:0] req1_b,
    output logic               req1_ready,
    output logic [FLOAT_W-1:0] mul_a,
    output logic [FLOAT_W-1:0] mul_b,
    input  logic [FLOAT_W-1:0] mul_result,
    input  logic               mul_overflow,
    input  logic               mul_underflow,
    output logic               res0_valid,
    output logic [FLOAT_W-1:0] res0_data,
    output logic               res0_ovf,
    output logic               res0_unf,
    input  logic               res0_ready,
    output logic               res1_valid,
    output logic [FLOAT_W-1:0] res1_data,
    output logic               res1_ovf,
    output logic               res1_unf,
    input  logic               res1_ready,
    output logic               busy
);

    localparam int            CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [CW-1:0]  cnt0, cnt1;
    logic [CW-1:0]  occ0, occ1;
    logic           last_grant;
    logic           elig0, elig1;
    logic           grant0, grant1;
    logic           pop0, pop1;
    logic           push0, push1;
    logic [LATENCY:0] tag_valid;
    logic [LATENCY:0] tag_id;
    fmul_result_t   push_word;
    fmul_result_t   head0, head1;

    assign elig0  = req0_valid && (cnt0 < FULL);
    assign elig1  = req1_valid && (cnt1 < FULL);
    // last_grant high means requester 1 was served last, so 0 wins a tie.
    assign grant0 = elig0 && (!elig1 || last_grant);
    assign grant1 = elig1 && (!elig0 || !last_grant);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign pop0 = res0_valid && res0_ready;
    assign pop1 = res1_valid && res1_ready;

    // Stage 0 travels with mul_a/mul_b; stage LATENCY lines up with mul_result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid  <= '0;
            tag_id     <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            last_grant <= 1'b1;
            cnt0       <= '0;
            cnt1       <= '0;
        end else begin
            tag_valid <= {tag_valid[LATENCY-1:0], grant0 | grant1};
            tag_id    <= {tag_id[LATENCY-1:0], grant1};
            if (grant0 || grant1) begin
                mul_a      <= grant1 ? req1_a : req0_a;
                mul_b      <= grant1 ? req1_b : req0_b;
                last_grant <= grant1;
            end else begin
                mul_a <= '0;
                mul_b <= '0;
            end
            cnt0 <= cnt0 + CW'(grant0) - CW'(pop0);
            cnt1 <= cnt1 + CW'(grant1) - CW'(pop1);
        end
    end

    assign push0     = tag_valid[LATENCY] && !tag_id[LATENCY];
    assign push1     = tag_valid[LATENCY] &&  tag_id[LATENCY];
    assign push_word = '{data: mul_result, ovf: mul_overflow, unf: mul_underflow};

    fmul_result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(RESULT_W)) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (push_word),
        .pop       (pop0),
        .head      (head0),
        .valid     (res0_valid),
        .count     (occ0)
    );

    fmul_result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(RESULT_W)) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (push_word),
        .pop       (pop1),
        .head      (head1),
        .valid     (res1_valid),
        .count     (occ1)
    );

    assign res0_data = res0_valid ? head0.data : '0;
    assign res0_ovf  = res0_valid && head0.ovf;
    assign res0_unf  = res0_valid && head0.unf;
    assign res1_data = res1_valid ? head1.data : '0;
    assign res1_ovf  = res1_valid && head1.ovf;
    assign res1_unf  = res1_valid && head1.unf;

    assign busy = (|tag_valid) || (occ0 != '0) || (occ1 != '0);

endmodule

// File: tb/tb_fmul_arbiter.sv
// Self-checking bench for fmul_arbiter: XOR multiplier stub, queue-based
// reference model of credits/arbitration/FIFOs, directed scenarios then random traffic.
module tb_fmul_arbiter;
    import fmul_pkg::*;

    localparam int LATENCY    = 5;
    localparam int FIFO_DEPTH = 4;

    logic        clk, rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [23:0] req0_a, req0_b, req1_a, req1_b;
    logic [23:0] mul_a, mul_b, mul_result;
    logic        mul_overflow, mul_underflow;
    logic        res0_valid, res1_valid, res0_ready, res1_ready;
    logic [23:0] res0_data, res1_data;
    logic        res0_ovf, res0_unf, res1_ovf, res1_unf;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fmul_arbiter #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .mul_overflow(mul_overflow), .mul_underflow(mul_underflow),
        .res0_valid(res0_valid), .res0_data(res0_data), .res0_ovf(res0_ovf),
        .res0_unf(res0_unf), .res0_ready(res0_ready),
        .res1_valid(res1_valid), .res1_data(res1_data), .res1_ovf(res1_ovf),
        .res1_unf(res1_unf), .res1_ready(res1_ready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stub: LATENCY registers after mul_a/mul_b, ignores reset.
    logic [23:0] pipe_d [LATENCY];
    logic        pipe_o [LATENCY];
    logic        pipe_u [LATENCY];

    initial begin
        for (int i = 0; i < LATENCY; i++) begin
            pipe_d[i] = '0;
            pipe_o[i] = 1'b0;
            pipe_u[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        pipe_d[0] <= mul_a ^ mul_b;
        pipe_o[0] <= (mul_a[23:16] == 8'h7F);
        pipe_u[0] <= (mul_a[23:16] == 8'h01);
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] <= pipe_d[i-1];
            pipe_o[i] <= pipe_o[i-1];
            pipe_u[i] <= pipe_u[i-1];
        end
    end

    assign mul_result    = pipe_d[LATENCY-1];
    assign mul_overflow  = pipe_o[LATENCY-1];
    assign mul_underflow = pipe_u[LATENCY-1];

    // Reference model: ops in flight carry the edge at which they land in a FIFO.
    typedef struct {
        int unsigned done;
        bit          id;
        logic [25:0] res;
    } op_t;

    op_t         inflight[$];
    logic [25:0] rq0[$];
    logic [25:0] rq1[$];
    bit          last_g;
    int unsigned cyc;
    logic [23:0] exp_a, exp_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int credit(input bit id);
        int n = id ? rq1.size() : rq0.size();
        foreach (inflight[i]) if (inflight[i].id == id) n++;
        return n;
    endfunction

    function automatic logic [1:0] model_grants();
        bit e0 = req0_valid && (credit(1'b0) < FIFO_DEPTH);
        bit e1 = req1_valid && (credit(1'b1) < FIFO_DEPTH);
        if (e0 && e1) return last_g ? 2'b01 : 2'b10;
        return {e1, e0};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight.delete();
            rq0.delete();
            rq1.delete();
            last_g = 1'b1;
            exp_a  = '0;
            exp_b  = '0;
            cyc    = 0;
        end else begin
            logic [1:0]  g;
            logic [23:0] a, b;
            op_t         o;
            g = model_grants();
            if (res0_ready && rq0.size() > 0) void'(rq0.pop_front());
            if (res1_ready && rq1.size() > 0) void'(rq1.pop_front());
            cyc++;
            while (inflight.size() > 0 && inflight[0].done == cyc) begin
                o = inflight.pop_front();
                chk("fifo_no_overflow", o.id ? rq1.size() : rq0.size(), (o.id ? rq1.size() : rq0.size()) < FIFO_DEPTH ? (o.id ? rq1.size() : rq0.size()) : FIFO_DEPTH - 1);
                if (o.id) rq1.push_back(o.res); else rq0.push_back(o.res);
            end
            if (g != 2'b00) begin
                a = g[1] ? req1_a : req0_a;
                b = g[1] ? req1_b : req0_b;
                inflight.push_back('{cyc + LATENCY + 1, g[1],
                                     {a ^ b, a[23:16] == 8'h7F, a[23:16] == 8'h01}});
                last_g = g[1];
                exp_a  = a;
                exp_b  = b;
            end else begin
                exp_a = '0;
                exp_b = '0;
            end
        end
    end

    task automatic checkOutput();
        logic [1:0] g = model_grants();
        chk("req0_ready", req0_ready, g[0]);
        chk("req1_ready", req1_ready, g[1]);
        chk("res0_valid", res0_valid, rq0.size() > 0);
        chk("res1_valid", res1_valid, rq1.size() > 0);
        chk("res0_word", {res0_data, res0_ovf, res0_unf}, rq0.size() > 0 ? 32'(rq0[0]) : 32'd0);
        chk("res1_word", {res1_data, res1_ovf, res1_unf}, rq1.size() > 0 ? 32'(rq1[0]) : 32'd0);
        chk("busy", busy, inflight.size() > 0 || rq0.size() > 0 || rq1.size() > 0);
        chk("mul_a", mul_a, exp_a);
        chk("mul_b", mul_b, exp_b);
    endtask

    task automatic applyStimulus(input bit v0, input logic [23:0] a0, input logic [23:0] b0,
                                 input bit v1, input logic [23:0] a1, input logic [23:0] b1,
                                 input bit r0, input bit r1);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        res0_ready = r0; res1_ready = r1;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        req0_valid = 0; req1_valid = 0;
        #1 rst = 1'b1;
        #1;
        checkOutput();
        chk("reset_busy", busy, 0);
        chk("reset_outputs", {res0_valid, res1_valid, req0_ready, req1_ready, res0_data, res1_data}, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [23:0] rnd_a();
        logic [23:0] v = 24'($urandom);
        case ($urandom_range(0, 3))
            0: v[23:16] = 8'h7F;
            1: v[23:16] = 8'h01;
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        int acc, n;
        logic [25:0] got [2];

        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        res0_ready = 0; res1_ready = 0;
        #1;
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        // Single op: result visible exactly 6 cycles after the accept edge.
        applyStimulus(1, 24'h123456, 24'h00FF00, 0, 0, 0, 1, 1);
        chk("single_accept", req0_ready, 1);
        for (int i = 1; i <= 9; i++) begin
            idle(1);
            chk("single_res0_valid", res0_valid, i == 7);
            chk("single_res1_valid", res1_valid, 0);
            if (i == 7) chk("single_res0_data", res0_data, 24'h12CB56);
            if (i >= 8) chk("single_busy_done", busy, 0);
        end

        // Contention: strict alternation starting with requester 0.
        pulseReset();
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1, rnd_a(), 24'($urandom), 1, rnd_a(), 24'($urandom), 1, 1);
            chk("contend_g0", req0_ready, (k % 2) == 0);
            chk("contend_g1", req1_ready, (k % 2) == 1);
        end
        idle(10);

        // Backpressure on result 0: four credits, requester 1 still served.
        pulseReset();
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            bit v1 = (k == 8 || k == 9);
            applyStimulus(1, rnd_a(), 24'($urandom), v1, rnd_a(), 24'($urandom), 0, 1);
            if (req0_ready) acc++;
            if (v1) chk("bp_req1_served", req1_ready, 1);
        end
        chk("bp_accepts", acc, 4);
        // Full-credit boundary: pop and valid together, credit usable next cycle.
        applyStimulus(1, rnd_a(), 24'($urandom), 0, 0, 0, 1, 1);
        chk("bp_full_valid", res0_valid, 1);
        chk("bp_full_ready", req0_ready, 0);
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1, rnd_a(), 24'($urandom), 0, 0, 0, 0, 1);
            if (k == 0) chk("bp_freed_ready", req0_ready, 1);
            if (req0_ready) acc++;
        end
        chk("bp_extra_accepts", acc, 1);
        idle(12);

        // Flags travel with their result; the next result has them clear.
        pulseReset();
        applyStimulus(0, 0, 0, 1, 24'h7F0001, 24'h000000, 1, 1);
        applyStimulus(0, 0, 0, 1, 24'h001234, 24'h000001, 1, 1);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            idle(1);
            if (res1_valid && n < 2) begin
                got[n] = {res1_data, res1_ovf, res1_unf};
                n++;
            end
        end
        chk("flags_count", n, 2);
        chk("flags_first", got[0], {24'h7F0001, 1'b1, 1'b0});
        chk("flags_second", got[1], {24'h001235, 1'b0, 1'b0});

        // Reset with three ops in flight: stub results afterwards are ignored.
        pulseReset();
        applyStimulus(1, 24'h010203, 24'h000F00, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 24'h7F1111, 24'h000001, 1, 1);
        applyStimulus(1, 24'h222222, 24'h111111, 0, 0, 0, 1, 1);
        pulseReset();
        for (int k = 0; k < 10; k++) begin
            idle(1);
            chk("rst_mid_res", {res0_valid, res1_valid, busy}, 0);
        end
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, rnd_a(), 24'($urandom), 0, 0, 0, 0, 1);
            if (req0_ready) acc++;
        end
        chk("rst_mid_credits", acc, 4);
        idle(12);

        // Random traffic against the model.
        pulseReset();
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 9) < 7, rnd_a(), 24'($urandom),
                          $urandom_range(0, 9) < 7, rnd_a(), 24'($urandom),
                          $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
        end
        idle(20);
        chk("final_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
